// File: rtl/alu_arbiter.sv
// Purpose : round-robin arbiter/sequencer sharing one registered ALU among NREQ requesters.
// Latency : valid op acks 3 cycles after the request is seen in IDLE, invalid op acks after 1; one op per 4 cycles max.
// Backpressure: requests are level-held; any req raised while busy simply waits for the next IDLE cycle.
//
// Ports:
//   clk, res          clock (rising edge), asynchronous active-low reset
//   req               level request per requester
//   req_op/l/r        packed per-requester opcode (4b) and operands (DW each)
//   ack/result/err    one-hot one-cycle completion pulse, result, reject flag
//   busy              high whenever the sequencer is not idle
//   alu_op/l/r        registered drive into the ALU; alu_op is NOP outside ISSUE
//   alu_obus          ALU result bus, sampled only in WAIT
module alu_arbiter #(
   parameter int DW   = 16,
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              res,
   input  logic [NREQ-1:0]    req,
   input  logic [4*NREQ-1:0]  req_op,
   input  logic [DW*NREQ-1:0] req_l,
   input  logic [DW*NREQ-1:0] req_r,
   output logic [NREQ-1:0]    ack,
   output logic [DW-1:0]      result,
   output logic               err,
   output logic               busy,
   output logic [3:0]         alu_op,
   output logic [DW-1:0]      alu_l,
   output logic [DW-1:0]      alu_r,
   input  logic [DW-1:0]      alu_obus
);

   // Opcode table shared with the ALU.
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [DW-1:0]     result_q, result_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [DW-1:0]     alu_l_q, alu_l_d;
   logic [DW-1:0]     alu_r_q, alu_r_d;

   logic              win_vld;
   logic [PW-1:0]     win_idx;
   logic [3:0]        win_op;
   logic [DW-1:0]     win_l;
   logic [DW-1:0]     win_r;
   logic              win_ok;

   // Round-robin pick: search starts one past the last winner and wraps.
   // Iterating from the farthest candidate down lets the nearest active
   // requester overwrite the result, so no early exit is needed.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [PW-1:0]   p);
      logic [PW-1:0] w;
      int            c;
      w = '0;
      for (int k = NREQ; k >= 1; k--) begin
         c = int'(p) + k;
         if (c >= NREQ) c = c - NREQ;
         if (r[c]) w = PW'(c);
      end
      return w;
   endfunction

   function automatic logic op_valid(input logic [3:0] op);
      logic v;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: v = 1'b1;
         default:                               v = 1'b0;
      endcase
      return v;
   endfunction

   assign win_vld = |req;
   assign win_idx = rr_pick(req, ptr_q);
   assign win_op  = req_op[4*int'(win_idx) +: 4];
   assign win_l   = req_l[DW*int'(win_idx) +: DW];
   assign win_r   = req_r[DW*int'(win_idx) +: DW];
   assign win_ok  = op_valid(win_op);

   // State and all registered outputs.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q  <= S_IDLE;
         ptr_q    <= PW'(NREQ - 1);
         gnt_q    <= '0;
         ack_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         alu_op_q <= OP_NOP;
         alu_l_q  <= '0;
         alu_r_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         ack_q    <= ack_d;
         result_q <= result_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         alu_op_q <= alu_op_d;
         alu_l_q  <= alu_l_d;
         alu_r_q  <= alu_r_d;
      end
   end

   // Next state, pointer and grant.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               gnt_d   = win_idx;
               ptr_d   = win_idx;
               // Rejected ops skip the ALU entirely and ack straight away.
               state_d = win_ok ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      alu_op_d = OP_NOP;   // ALU holds Obus on every cycle but ISSUE
      alu_l_d  = alu_l_q;
      alu_r_d  = alu_r_q;
      ack_d    = '0;
      err_d    = 1'b0;
      result_d = result_q;
      busy_d   = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               if (win_ok) begin
                  alu_op_d = win_op;
                  alu_l_d  = win_l;
                  alu_r_d  = win_r;
               end else begin
                  ack_d    = NREQ'(1) << win_idx;
                  err_d    = 1'b1;
                  result_d = '0;
               end
            end
         end
         S_WAIT: begin
            // Only point where Obus is trusted: one cycle after ISSUE.
            result_d = alu_obus;
            ack_d    = NREQ'(1) << gnt_q;
            err_d    = 1'b0;
         end
         default: ;
      endcase
   end

   assign ack    = ack_q;
   assign result = result_q;
   assign err    = err_q;
   assign busy   = busy_q;
   assign alu_op = alu_op_q;
   assign alu_l  = alu_l_q;
   assign alu_r  = alu_r_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   localparam int DW   = 16;
   localparam int NREQ = 4;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;

   logic              clk = 1'b0;
   logic              res;
   logic [NREQ-1:0]    req;
   logic [4*NREQ-1:0]  req_op;
   logic [DW*NREQ-1:0] req_l, req_r;
   logic [NREQ-1:0]    ack;
   logic [DW-1:0]      result;
   logic              err, busy;
   logic [3:0]         alu_op;
   logic [DW-1:0]      alu_l, alu_r, alu_obus;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
      .clk(clk), .res(res), .req(req), .req_op(req_op), .req_l(req_l), .req_r(req_r),
      .ack(ack), .result(result), .err(err), .busy(busy),
      .alu_op(alu_op), .alu_l(alu_l), .alu_r(alu_r), .alu_obus(alu_obus)
   );

   function automatic bit op_ok(input logic [3:0] op);
      return (op === OP_ADD) || (op === OP_SUB) || (op === OP_AND) ||
             (op === OP_OR)  || (op === OP_XOR);
   endfunction

   function automatic logic [DW-1:0] calc(input logic [3:0] op, input logic [DW-1:0] l, input logic [DW-1:0] r);
      case (op)
         OP_ADD:  return l + r;
         OP_SUB:  return l - r;
         OP_AND:  return l & r;
         OP_OR:   return l | r;
         OP_XOR:  return l ^ r;
         default: return '0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // ALU stand-in: registers a result when issued, presents it for exactly the
   // following cycle, and shows junk otherwise so off-cycle sampling is caught.
   logic [DW-1:0] alu_hold = '0;
   logic [DW-1:0] junk     = '0;
   bit            alu_fresh = 1'b0;
   always @(posedge clk) begin
      junk <= DW'($urandom);
      if (op_ok(alu_op)) begin
         alu_hold  <= calc(alu_op, alu_l, alu_r);
         alu_fresh <= 1'b1;
      end else begin
         alu_fresh <= 1'b0;
      end
   end
   assign alu_obus = alu_fresh ? alu_hold : junk;

   // Reference model: tracks when the arbiter is free, rotates a pointer,
   // and pushes the expected completion for every grant.
   typedef struct {
      int            idx;
      logic [DW-1:0] val;
      bit            e;
      int            at;
   } exp_t;
   exp_t sb[$];

   int            m_ptr     = NREQ - 1;
   int            idle_from = 0;
   int            iss_cyc   = -1;
   logic [3:0]    iss_op    = OP_NOP;
   logic [DW-1:0] iss_l     = '0;
   logic [DW-1:0] iss_r     = '0;

   always @(posedge clk) begin
      if (res === 1'b1 && req != '0 && cyc >= idle_from) begin
         int            w;
         exp_t          e;
         logic [3:0]    op;
         logic [DW-1:0] l, r;
         w = -1;
         for (int k = 1; k <= NREQ; k++)
            if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         op    = req_op[4*w +: 4];
         l     = req_l[DW*w +: DW];
         r     = req_r[DW*w +: DW];
         m_ptr = w;
         e.idx = w;
         if (op_ok(op)) begin
            e.val = calc(op, l, r); e.e = 1'b0; e.at = cyc + 3;
            idle_from = cyc + 4;
            iss_cyc = cyc + 1; iss_op = op; iss_l = l; iss_r = r;
         end else begin
            e.val = '0; e.e = 1'b1; e.at = cyc + 1;
            idle_from = cyc + 2;
         end
         sb.push_back(e);
      end
      cyc++;
   end

   always @(negedge res) begin
      sb.delete();
      m_ptr     = NREQ - 1;
      idle_from = 0;
      iss_cyc   = -1;
   end

   // Monitor: per-cycle interface checks and scoreboard pops on ack.
   always @(negedge clk) begin
      if (res === 1'b1) begin
         check("busy", 32'(busy), 32'(cyc < idle_from));
         check("alu_op", 32'(alu_op), 32'((cyc == iss_cyc) ? iss_op : OP_NOP));
         if (cyc == iss_cyc) begin
            check("alu_l", 32'(alu_l), 32'(iss_l));
            check("alu_r", 32'(alu_r), 32'(iss_r));
         end
         if (ack !== '0) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_ack");
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("ack_vec", 32'(ack), 32'(1) << e.idx);
               check("result", 32'(result), 32'(e.val));
               check("err", 32'(err), 32'(e.e));
               check("ack_cycle", cyc, e.at);
            end
         end else if (sb.size() > 0 && cyc > sb[0].at) begin
            fail_now("missing_ack");
            void'(sb.pop_front());
         end
      end
   end

   task automatic set_req(input int i, input logic [3:0] op, input logic [DW-1:0] l, input logic [DW-1:0] r);
      req_op[4*i +: 4]   = op;
      req_l[DW*i +: DW]  = l;
      req_r[DW*i +: DW]  = r;
   endtask

   function automatic logic [3:0] rand_op();
      if ($urandom_range(0, 4) != 0) return 4'($urandom_range(1, 5));
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_ack"},    32'(ack),    32'(0));
      check({tag, "_result"}, 32'(result), 32'(0));
      check({tag, "_err"},    32'(err),    32'(0));
      check({tag, "_busy"},   32'(busy),   32'(0));
      check({tag, "_alu_op"}, 32'(alu_op), 32'(OP_NOP));
      check({tag, "_alu_l"},  32'(alu_l),  32'(0));
      check({tag, "_alu_r"},  32'(alu_r),  32'(0));
   endtask

   // Single request; operands/opcode are scrambled once the block is busy,
   // so the result must come from the values latched at grant.
   task automatic serve(input int i, input logic [3:0] op, input logic [DW-1:0] l, input logic [DW-1:0] r,
                        input logic [DW-1:0] want, input logic want_err, input int lat, input string tag);
      int t;
      bit got;
      @(negedge clk);
      set_req(i, op, l, r);
      req[i] = 1'b1;
      t = cyc;
      got = 1'b0;
      for (int n = 0; n < 12 && !got; n++) begin
         @(negedge clk);
         if (ack[i] === 1'b1) got = 1'b1;
         else if (busy === 1'b1) set_req(i, 4'($urandom), DW'($urandom), DW'($urandom));
      end
      req[i] = 1'b0;
      if (got) begin
         check({tag, "_result"},  32'(result), 32'(want));
         check({tag, "_err"},     32'(err),    32'(want_err));
         check({tag, "_latency"}, cyc - t,     lat);
      end else begin
         fail_now({tag, "_timeout"});
      end
   endtask

   initial begin
      int k;
      int t;
      bit got;
      res = 1'b1; req = '0; req_op = '0; req_l = '0; req_r = '0;
      #3 res = 1'b0;
      #1 check_reset_vals("reset");
      repeat (2) @(negedge clk);
      res = 1'b1;

      // Single ADD, SUB wrap, XOR, invalid ops, operand hold-off.
      serve(0, OP_ADD, 16'h1234, 16'h0101, 16'h1335, 1'b0, 3, "add");
      serve(2, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 3, "sub_wrap");
      serve(2, OP_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 3, "xor");
      serve(1, OP_NOP, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1, "inv_nop");
      serve(1, 4'hF,   16'h3333, 16'h4444, 16'h0000, 1'b1, 1, "inv_f");
      serve(3, OP_AND, 16'hABCD, 16'h0FF0, 16'h0BC0, 1'b0, 3, "and_hold");
      serve(0, OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 3, "or");

      // Contention from a fresh reset: strict rotation 0,1,2,3,...
      @(negedge clk);
      #2 res = 1'b0;
      @(negedge clk);
      res = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom_range(1, 5)), DW'($urandom), DW'($urandom));
      req = '1;
      k = 0;
      for (int n = 0; n < 100 && k < 12; n++) begin
         @(negedge clk);
         if (ack !== '0) begin
            for (int i = 0; i < NREQ; i++)
               if (ack[i] === 1'b1) begin
                  check("rr_order", i, k % NREQ);
                  set_req(i, 4'($urandom_range(1, 5)), DW'($urandom), DW'($urandom));
               end
            k++;
         end
      end
      if (k < 12) fail_now("rr_timeout");
      req = '0;
      repeat (4) @(negedge clk);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && ack[i] === 1'b1) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               else set_req(i, rand_op(), DW'($urandom), DW'($urandom));
            end else if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  set_req(i, rand_op(), DW'($urandom), DW'($urandom));
                  req[i] = 1'b1;
               end
            end else if (busy === 1'b1 && $urandom_range(0, 1) == 0) begin
               set_req(i, rand_op(), DW'($urandom), DW'($urandom));
            end
         end
      end
      req = '0;
      repeat (8) @(negedge clk);

      // Reset during WAIT aborts the op; the held request is re-served.
      @(negedge clk);
      set_req(3, OP_ADD, 16'h0007, 16'h0008);
      req[3] = 1'b1;
      @(negedge clk);   // ISSUE
      @(negedge clk);   // WAIT
      #2 res = 1'b0;
      #1 check_reset_vals("midop_reset");
      repeat (2) @(negedge clk);
      check("reset_hold_ack", 32'(ack), 32'(0));
      res = 1'b1;
      t = cyc;
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (ack[3] === 1'b1) got = 1'b1;
      end
      req[3] = 1'b0;
      if (got) begin
         check("reserve_result",  32'(result), 32'h000F);
         check("reserve_latency", cyc - t, 3);
      end else begin
         fail_now("reserve_timeout");
      end

      repeat (8) @(negedge clk);
      check("sb_drain", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
